// File: rtl/dlfloat16_cmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dlfloat16_cmp_ctrl
//  Brief    : Sequencer for a registered DLFloat16 comparator unit. Accepts
//             one min/max/eq/lt/le request at a time, issues it to the
//             comparator, applies NaN / illegal-op handling around the
//             comparator result and presents it on a ready/valid output with
//             OR-accumulated sticky flags.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module dlfloat16_cmp_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  // request handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  // comparator drive
  output logic [15:0] cmp_a1,
  output logic [15:0] cmp_b1,
  output logic [2:0]  cmp_sel,
  output logic [3:0]  cmp_ena,
  // comparator registered result
  input  logic [15:0] cmp_c_out,
  input  logic [4:0]  cmp_exceptions,
  // result handshake
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [4:0]  out_flags,
  // status
  output logic [4:0]  sticky_flags,
  input  logic        flags_clr,
  output logic        busy
);

  localparam logic [3:0]  c_ENA_ISSUE  = 4'b0110;
  localparam logic [3:0]  c_ENA_OFF    = 4'b0000;
  localparam logic [15:0] c_QNAN       = 16'h7F00;
  localparam logic [4:0]  c_FLAG_INV   = 5'b10000;
  localparam logic [2:0]  c_OP_MIN     = 3'd1;
  localparam logic [2:0]  c_OP_MAX     = 3'd2;
  localparam logic [2:0]  c_OP_LE      = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;

  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_op_legal;
  logic        w_op_minmax;
  logic [15:0] w_result;
  logic [4:0]  w_flags;
  logic        w_out_hs;

  assign w_out_hs = out_valid & out_ready;

  // Final result selection from the latched operands and the comparator output
  always_comb begin
    w_a_nan     = (cmp_a1[14:9] == 6'h3F) && (cmp_a1[8:0] != 9'd0);
    w_b_nan     = (cmp_b1[14:9] == 6'h3F) && (cmp_b1[8:0] != 9'd0);
    w_op_legal  = (cmp_sel >= c_OP_MIN) && (cmp_sel <= c_OP_LE);
    w_op_minmax = (cmp_sel == c_OP_MIN) || (cmp_sel == c_OP_MAX);
    // Comparator bits 3:0 carry a result pattern rather than exceptions.
    w_result    = cmp_c_out;
    w_flags     = {cmp_exceptions[4], cmp_exceptions[3:0] & 4'b0000};
    if (!w_op_legal) begin
      w_result = 16'h0000;
      w_flags  = c_FLAG_INV;
    end else if (w_a_nan || w_b_nan) begin
      w_flags = c_FLAG_INV;
      if (w_op_minmax) begin
        if (w_a_nan && w_b_nan) begin
          w_result = c_QNAN;
        end else if (w_a_nan) begin
          w_result = cmp_b1;
        end else begin
          w_result = cmp_a1;
        end
      end else begin
        w_result = 16'h0000;
      end
    end
  end

  // Control FSM with registered handshake, status and comparator-drive outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      cmp_a1     <= 16'h0000;
      cmp_b1     <= 16'h0000;
      cmp_sel    <= 3'd0;
      cmp_ena    <= c_ENA_OFF;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_flags  <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            cmp_a1   <= a;
            cmp_b1   <= b;
            cmp_sel  <= op;
            cmp_ena  <= c_ENA_ISSUE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_ISSUE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          cmp_ena <= c_ENA_OFF;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          out_result <= w_result;
          out_flags  <= w_flags;
          out_valid  <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          cmp_ena  <= c_ENA_OFF;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a clear coinciding with a handshake keeps only the new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= 5'd0;
    end else if (w_out_hs) begin
      sticky_flags <= flags_clr ? out_flags : (sticky_flags | out_flags);
    end else if (flags_clr) begin
      sticky_flags <= 5'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dlfloat16_cmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlfloat16_cmp_ctrl
//  Brief    : Self-checking bench for dlfloat16_cmp_ctrl with a behavioural
//             comparator unit and a value-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dlfloat16_cmp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] cmp_a1;
  logic [15:0] cmp_b1;
  logic [2:0]  cmp_sel;
  logic [3:0]  cmp_ena;
  logic [15:0] cmp_c_out;
  logic [4:0]  cmp_exceptions;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [4:0]  out_flags;
  logic [4:0]  sticky_flags;
  logic        flags_clr;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  logic [4:0]  exp_sticky = 5'd0;
  bit          exc_rand_en = 1'b0;
  logic [4:0]  issued_exc = 5'd0;
  logic [4:0]  exc_v;

  dlfloat16_cmp_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op             (op),
    .a              (a),
    .b              (b),
    .cmp_a1         (cmp_a1),
    .cmp_b1         (cmp_b1),
    .cmp_sel        (cmp_sel),
    .cmp_ena        (cmp_ena),
    .cmp_c_out      (cmp_c_out),
    .cmp_exceptions (cmp_exceptions),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags),
    .sticky_flags   (sticky_flags),
    .flags_clr      (flags_clr),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ordering key: sign-magnitude value as a signed integer (+0 == -0)
  function automatic int fkey(input logic [15:0] x);
    int mag;
    mag = int'(x[14:0]);
    return x[15] ? -mag : mag;
  endfunction

  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:9] == 6'h3F) && (x[8:0] != 9'd0);
  endfunction

  // Behavioural comparator function: boolean results are all-ones / all-zeros
  function automatic logic [15:0] cmp_unit(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    int kx;
    int ky;
    kx = fkey(x);
    ky = fkey(y);
    case (o)
      3'd1:    return (kx <= ky) ? x : y;
      3'd2:    return (kx >= ky) ? x : y;
      3'd3:    return (kx == ky) ? 16'hFFFF : 16'h0000;
      3'd4:    return (kx <  ky) ? 16'hFFFF : 16'h0000;
      3'd5:    return (kx <= ky) ? 16'hFFFF : 16'h0000;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Expected controller output for one request
  task automatic ref_model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic exc4, output logic [15:0] r, output logic [4:0] f);
    if (o == 3'd0 || o > 3'd5) begin
      r = 16'h0000;
      f = 5'b10000;
    end else if (is_nan(x) || is_nan(y)) begin
      f = 5'b10000;
      if (o <= 3'd2) r = (is_nan(x) && is_nan(y)) ? 16'h7F00 : (is_nan(x) ? y : x);
      else           r = 16'h0000;
    end else begin
      r = cmp_unit(o, x, y);
      f = {exc4, 4'b0000};
    end
  endtask

  // Comparator unit model: valid result one cycle after the enable, garbage otherwise
  always @(posedge clk) begin
    if (cmp_ena == 4'b0110) begin
      exc_v = 5'($urandom);
      if (!exc_rand_en) exc_v[4] = 1'b0;
      cmp_c_out      <= cmp_unit(cmp_sel, cmp_a1, cmp_b1);
      cmp_exceptions <= exc_v;
      issued_exc     <= exc_v;
    end else begin
      cmp_c_out      <= 16'($urandom);
      cmp_exceptions <= 5'($urandom);
    end
  end

  task automatic do_txn(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input bit er, input int hold, input bit clr);
    logic [15:0] er_r;
    logic [4:0]  ef;
    int n;
    exc_rand_en = er;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_ready_wait in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    checks++;
    if (cmp_ena !== 4'b0110 || cmp_a1 !== x || cmp_b1 !== y || cmp_sel !== o ||
        busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL issue ena=%h a1=%h b1=%h sel=%0d busy=%b rdy=%b ov=%b want 6 %h %h %0d 1 0 0",
               cmp_ena, cmp_a1, cmp_b1, cmp_sel, busy, in_ready, out_valid, x, y, o);
    end
    @(negedge clk);
    checks++;
    if (cmp_ena !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait ena=%h ov=%b busy=%b want 0 0 1", cmp_ena, out_valid, busy);
    end
    @(negedge clk);
    ref_model(o, x, y, issued_exc[4], er_r, ef);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency out_valid=%b want 1 at T+3", out_valid);
    end
    checks++;
    if (out_result !== er_r || out_flags !== ef) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got %h/%b want %h/%b", o, x, y, out_result, out_flags, er_r, ef);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== er_r || out_flags !== ef || in_ready !== 1'b0 ||
          cmp_a1 !== x || cmp_b1 !== y || cmp_sel !== o) begin
        errors++;
        $display("FAIL hold ov=%b res=%h fl=%b rdy=%b a1=%h b1=%h want 1 %h %b 0 %h %h",
                 out_valid, out_result, out_flags, in_ready, cmp_a1, cmp_b1, er_r, ef, x, y);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; flags_clr = clr;
    @(negedge clk);
    out_ready = 1'b0; flags_clr = 1'b0;
    exp_sticky = clr ? ef : (exp_sticky | ef);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sticky_flags !== exp_sticky) begin
      errors++;
      $display("FAIL handshake ov=%b rdy=%b busy=%b sticky=%b want 0 1 0 %b",
               out_valid, in_ready, busy, sticky_flags, exp_sticky);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0 || out_flags !== 5'd0 || sticky_flags !== 5'd0 ||
        cmp_a1 !== 16'h0 || cmp_b1 !== 16'h0 || cmp_sel !== 3'd0 || cmp_ena !== 4'd0 ||
        busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ov=%b res=%h fl=%b st=%b a1=%h b1=%h sel=%0d ena=%h busy=%b rdy=%b want all 0",
               name, out_valid, out_result, out_flags, sticky_flags, cmp_a1, cmp_b1, cmp_sel, cmp_ena, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 16'h0; b = 16'h0;
    out_ready = 1'b0; flags_clr = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_directed();
    do_txn(3'd1, 16'h3E00, 16'h4000, 1'b0, 0, 1'b0);   // min(1.0, 2.0)
    do_txn(3'd4, 16'hBE00, 16'h3E00, 1'b0, 0, 1'b0);   // -1.0 < 1.0
    do_txn(3'd3, 16'hBE00, 16'h3E00, 1'b0, 0, 1'b0);   // -1.0 == 1.0
    do_txn(3'd2, 16'h7E01, 16'h4000, 1'b0, 0, 1'b0);   // max(NaN, 2.0)
    checks++;
    if (sticky_flags !== 5'b10000) begin
      errors++;
      $display("FAIL sticky_after_nan got %b want 10000", sticky_flags);
    end
    do_txn(3'd1, 16'h7E01, 16'hFFFF, 1'b0, 0, 1'b0);   // both NaN
    do_txn(3'd5, 16'h4000, 16'h7FFF, 1'b0, 0, 1'b0);   // le with NaN
    do_txn(3'd0, 16'h3E00, 16'h4000, 1'b0, 0, 1'b0);   // illegal ops
    do_txn(3'd6, 16'h3E00, 16'h4000, 1'b0, 0, 1'b0);
    do_txn(3'd7, 16'h7E01, 16'h4000, 1'b0, 0, 1'b0);
    do_txn(3'd3, 16'h0000, 16'h8000, 1'b1, 0, 1'b0);   // +0 == -0, invalid passthrough
  endtask

  task automatic test_backpressure();
    do_txn(3'd2, 16'h3E00, 16'hC000, 1'b0, 5, 1'b0);
  endtask

  task automatic test_reset_midflight();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; op = 3'd1; a = 16'h4200; b = 16'h3E00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_in_wait");
    exp_sticky = 5'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d ov=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    out_ready = 1'b0;
    do_txn(3'd5, 16'h4000, 16'h4000, 1'b0, 0, 1'b0);
  endtask

  task automatic test_sticky_clear();
    do_txn(3'd4, 16'hFE05, 16'h0000, 1'b0, 0, 1'b0);   // NaN -> sticky invalid
    do_txn(3'd1, 16'h3E00, 16'h4000, 1'b0, 0, 1'b1);   // clear with clean handshake
    checks++;
    if (sticky_flags !== 5'd0) begin
      errors++;
      $display("FAIL sticky_clr_hs got %b want 00000", sticky_flags);
    end
    do_txn(3'd6, 16'h0000, 16'h0000, 1'b0, 1, 1'b0);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    exp_sticky = 5'd0;
    checks++;
    if (sticky_flags !== 5'd0) begin
      errors++;
      $display("FAIL sticky_clr_idle got %b want 00000", sticky_flags);
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 5))
      0: v[14:0] = {6'h3F, 9'($urandom_range(1, 511))};
      1: v[14:0] = {6'h3F, 9'd0};
      2: v[14:0] = 15'd0;
      default: ;
    endcase
    return v;
  endfunction

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] y;
    for (int i = 0; i < 50; i++) begin
      x = rand_operand();
      y = ($urandom_range(0, 4) == 0) ? x : rand_operand();
      do_txn(3'($urandom), x, y, 1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end
  endtask

  task automatic test_back_to_back();
    do_txn(3'd2, 16'h3E00, 16'h4000, 1'b0, 0, 1'b0);
    do_txn(3'd4, 16'h4000, 16'h3E00, 1'b0, 0, 1'b0);
    do_txn(3'd1, 16'hC200, 16'hC000, 1'b1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_sticky_clear();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dlfloat16_cmp_ctrl.md
DLFLOAT16_CMP_CTRL -- requirements
Module: dlfloat16_cmp_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  in  1 / in_ready  out  1  request handshake.
REQ-004 SHALL have: op  in  3  1=min, 2=max, 3=eq, 4=lt, 5=le; 0,6,7 illegal.
REQ-005 SHALL have: a, b  in  16 each  DLFloat16 operands (sign[15], exp[14:9], mant[8:0]).
REQ-006 SHALL have: cmp_a1, cmp_b1  out  16, cmp_sel  out  3, cmp_ena  out  4  drive to comparator unit.
REQ-007 SHALL have: cmp_c_out  in  16, cmp_exceptions  in  5  comparator registered result and flags.
REQ-008 SHALL have: out_valid  out  1 / out_ready  in  1  result handshake.
REQ-009 SHALL have: out_result  out  16, out_flags  out  5  {invalid, inexact, overflow, underflow, div_zero}.
REQ-010 SHALL have: sticky_flags  out  5  OR-accumulated flags; flags_clr  in  1  clear; busy  out  1.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; one request in flight.
REQ-012 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-013 On in_valid&in_ready SHALL latch op, a, b; go to ISSUE.
REQ-014 cmp_a1/cmp_b1/cmp_sel SHALL come from latched regs at all times; cmp_ena SHALL be 4'b0110 in ISSUE only, 4'b0000 otherwise.
REQ-015 ISSUE SHALL go to WAIT unconditionally; in WAIT, cmp_c_out is valid and SHALL be captured at the WAIT->DONE edge.
REQ-016 out_valid SHALL be 1 exactly in DONE; out_result/out_flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 Latency: accept in cycle T -> out_valid first high in cycle T+3; DONE->IDLE on out_ready=1; earliest next accept T+4.
REQ-018 NaN = exp==6'h3F and mant!=0; detection SHALL use latched operands.
REQ-019 min/max, exactly one NaN operand: out_result SHALL be the non-NaN operand; both NaN: 16'h7F00; out_flags[4]=1.
REQ-020 eq/lt/le with any NaN operand: out_result SHALL be 16'h0000, out_flags[4]=1.
REQ-021 Illegal op: out_result SHALL be 16'h0000, out_flags=5'b10000.
REQ-022 No NaN, legal op: out_result SHALL be captured cmp_c_out; out_flags[4]=cmp_exceptions[4]; out_flags[3:0] SHALL be 0 (comparator bits 3:0 encode result pattern, not exceptions, and are masked).
REQ-023 On out_valid&out_ready SHALL set sticky_flags |= out_flags.
REQ-024 flags_clr=1 SHALL zero sticky_flags next edge; same-cycle clr and out handshake SHALL yield sticky_flags=out_flags.
REQ-025 in_valid while not IDLE SHALL be ignored (no latch, no state change).

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and zero all outputs and registers: out_valid=0, out_result=0, out_flags=0, sticky_flags=0, cmp_a1=0, cmp_b1=0, cmp_sel=0, cmp_ena=0, busy=0; in_ready=0 while rst_n=0, 1 from first edge after release.
REQ-027 Reset asserted in any state, including ISSUE/WAIT/DONE, SHALL discard the in-flight request; no out_valid for it after release.

Verification
REQ-028 op=1, a=16'h3E00 (1.0), b=16'h4000 (2.0) -> out_valid at T+3, out_result=16'h3E00, out_flags=0.
REQ-029 op=4, a=16'hBE00 (-1.0), b=16'h3E00 -> out_result=16'hFFFF, out_flags=0; op=3 same operands -> 16'h0000, out_flags=0.
REQ-030 op=2, a=16'h7E01 (NaN), b=16'h4000 -> out_result=16'h4000, out_flags=5'b10000, sticky_flags=5'b10000 after handshake.
REQ-031 out_ready=0 for 5 cycles in DONE -> out_result held, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-032 rst_n low during WAIT -> all outputs 0 asynchronously, no out_valid after release; then op=5, a=b=16'h4000 -> out_result=16'hFFFF.
REQ-033 sticky_flags=5'b10000, flags_clr=1 in same cycle as handshake with out_flags=0 -> sticky_flags=0.
